// File: rtl/riscv_pkg.sv
// Shared constants and small helpers for the RISC-V single-cycle datapath.
// Imported by the program counter and the other pipeline/state registers.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam int INSTR_BYTES = 4;

    // Instruction fetch is word aligned; any set bit in the low two PC bits is misaligned.
    function automatic logic is_misaligned(input logic [1:0] pc_low);
        return (pc_low != 2'b00);
    endfunction

endpackage

// File: rtl/dff_en_rst.sv
// Generic WIDTH-bit register with synchronous active-high reset and load enable.
// Reset has priority over enable; with enable low the register holds.
module dff_en_rst #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // State register: reset, then load, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else if (en) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/program_counter.sv
// Architectural PC register: loads the upstream next-PC on enabled edges and
// publishes PC+4 and a misalignment flag for the fetch stage.
module program_counter
    import riscv_pkg::*;
#(
    parameter int              XLEN         = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(riscv_pkg::RESET_VECTOR)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            EN,
    input  logic [XLEN-1:0] Address,
    output logic [XLEN-1:0] out_Result,
    output logic [XLEN-1:0] out_PCPlus4,
    output logic            out_Misaligned
);

    localparam logic [XLEN-1:0] INSTR_INCR = XLEN'(INSTR_BYTES);

    logic [XLEN-1:0] pc_r;

    // The next-PC is taken verbatim; alignment is only reported, never enforced.
    dff_en_rst #(
        .WIDTH       (XLEN),
        .RESET_VALUE (RESET_VECTOR)
    ) u_pc_reg (
        .clk (CLK),
        .rst (RST),
        .en  (EN),
        .d   (Address),
        .q   (pc_r)
    );

    assign out_Result     = pc_r;
    // Carry-out is dropped so the top of the address space wraps to zero.
    assign out_PCPlus4    = pc_r + INSTR_INCR;
    assign out_Misaligned = is_misaligned(pc_r[1:0]);

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: vector table driven through a
// scoreboard queue, plus hand sequences for mid-cycle reset and an aligned walk.
module tb_program_counter;

    logic        CLK;
    logic        RST;
    logic        EN;
    logic [31:0] Address;
    logic [31:0] out_Result;
    logic [31:0] out_PCPlus4;
    logic        out_Misaligned;

    int total_checks;
    int passed_checks;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] p4;
        logic        mis;
    } exp_t;

    typedef struct packed {
        logic        rst;
        logic        en;
        logic [31:0] addr;
        logic [31:0] res;
        logic [31:0] p4;
        logic        mis;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[16];

    program_counter dut (
        .CLK            (CLK),
        .RST            (RST),
        .EN             (EN),
        .Address        (Address),
        .out_Result     (out_Result),
        .out_PCPlus4    (out_PCPlus4),
        .out_Misaligned (out_Misaligned)
    );

    initial CLK = 1'b0;
    always #20 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog expired");
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        total_checks++;
        if (act === req) begin
            passed_checks++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Pop the oldest expectation and compare it with what the DUT shows now.
    task automatic sb_check(input string tag);
        exp_t ex;
        if (sb_q.size() == 0) begin
            total_checks++;
            $display("FAIL %s_sb: got empty scoreboard, expected an entry", tag);
        end else begin
            ex = sb_q.pop_front();
            check32({tag, "_result"}, out_Result, ex.res);
            check32({tag, "_plus4"}, out_PCPlus4, ex.p4);
            check32({tag, "_mis"}, {31'd0, out_Misaligned}, {31'd0, ex.mis});
        end
    endtask

    // Drive on the falling edge, record expectation, sample 1 unit after the rising edge.
    task automatic step(input logic r, input logic e, input logic [31:0] a,
                        input exp_t ex, input string tag);
        @(negedge CLK);
        RST = r;
        EN = e;
        Address = a;
        sb_q.push_back(ex);
        @(posedge CLK);
        #1;
        sb_check(tag);
    endtask

    initial begin
        exp_t        ex;
        logic [31:0] model_pc;

        total_checks = 0;
        passed_checks = 0;
        RST = 1'b0;
        EN = 1'b0;
        Address = 32'h0;

        //             rst   en    addr          result        plus4         mis
        vecs[0]  = '{1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0004, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 32'h0000_0123, 32'h0000_0000, 32'h0000_0004, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_0001, 32'h0000_0001, 32'h0000_0005, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 32'h0000_0005, 32'h0000_0005, 32'h0000_0009, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 32'h0000_0007, 32'h0000_0007, 32'h0000_000B, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 32'h0000_0007, 32'h0000_0007, 32'h0000_000B, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 32'h0000_0040, 32'h0000_0040, 32'h0000_0044, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 32'h0000_0080, 32'h0000_0000, 32'h0000_0004, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 32'h0000_0100, 32'h0000_0100, 32'h0000_0104, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 32'h0000_0200, 32'h0000_0100, 32'h0000_0104, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 32'h0000_0200, 32'h0000_0100, 32'h0000_0104, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 32'h0000_0200, 32'h0000_0100, 32'h0000_0104, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 32'h0000_0200, 32'h0000_0200, 32'h0000_0204, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 32'h0000_0003, 32'h0000_0003, 32'h0000_0007, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 32'h0000_0002, 32'h0000_0002, 32'h0000_0006, 1'b1};

        for (int i = 0; i < 16; i++) begin
            ex.res = vecs[i].res;
            ex.p4  = vecs[i].p4;
            ex.mis = vecs[i].mis;
            step(vecs[i].rst, vecs[i].en, vecs[i].addr, ex, $sformatf("vec%0d", i));
        end

        // Mid-cycle reset: PC is 2 here; RST pulsed between edges must not disturb it.
        @(negedge CLK);
        RST = 1'b1;
        EN = 1'b0;
        #5;
        check32("midrst_asserted", out_Result, 32'h0000_0002);
        #5;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        check32("midrst_released_hold", out_Result, 32'h0000_0002);

        // Reset sampled on an edge, then released with EN=1 loads Address.
        ex = '{32'h0000_0000, 32'h0000_0004, 1'b0};
        step(1'b1, 1'b0, 32'h0000_0055, ex, "rst_edge");
        ex = '{32'h0000_0044, 32'h0000_0048, 1'b0};
        step(1'b0, 1'b1, 32'h0000_0044, ex, "rst_release_load");

        // Aligned walk: reset, then feed out_PCPlus4 back into Address.
        model_pc = 32'h0;
        ex = '{model_pc, model_pc + 32'd4, 1'b0};
        step(1'b1, 1'b1, 32'h0000_0010, ex, "walk0");
        for (int k = 1; k < 8; k++) begin
            model_pc = model_pc + 32'd4;
            ex = '{model_pc, model_pc + 32'd4, 1'b0};
            @(negedge CLK);
            step(1'b0, 1'b1, out_PCPlus4, ex, $sformatf("walk%0d", k));
        end
        check32("walk_final", out_Result, 32'h0000_001C);

        if (sb_q.size() != 0) begin
            total_checks++;
            $display("FAIL sb_drain: got %0d leftover entries, expected 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
